io_cfg_frame_loader: RTL and testbench

Sequencer for the memory-bank configuration port of the I/O grid tiles. It accepts a serial configuration bitstream over a valid/ready handshake and writes one bit at a time. For each bit it drives the shared `address`/`data_in` bus and a one-hot per-tile `enable` strobe, so each tile's `enable`/`address`/`data_in` inputs are programmed without glitches. It sits between the bitstream source and the `enable` ports of the I/O tiles of one grid side.

---
 rtl/io_cfg_pkg.sv | 40 ++++
 rtl/io_cfg_bit_counter.sv | 51 +++++
 rtl/io_cfg_frame_loader.sv | 137 +++++++++++++
 tb/tb_io_cfg_frame_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_cfg_pkg.sv
// io_cfg_pkg
//   Shared definitions for the I/O-tile configuration frame loader:
//   - io_cfg_state_t   : loader FSM states
//   - IO_CFG_NUM_TILES : default number of I/O tiles on one grid side
//   - IO_CFG_ADDR_W    : default per-tile configuration address width
//   - io_cfg_tile_w()  : tile-counter width derived from the tile count
//   - io_cfg_one_hot() : one-hot enable vector for a tile index
package io_cfg_pkg;

  localparam int IO_CFG_NUM_TILES = 4;
  localparam int IO_CFG_ADDR_W    = 4;

  // Widest enable vector the one-hot helper can produce; callers size it down.
  localparam int IO_CFG_MAX_TILES = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BIT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE,
    S_ERR
  } io_cfg_state_t;

  // A single tile still needs a 1-bit counter so the port stays legal.
  function automatic int io_cfg_tile_w(input int num_tiles);
    return (num_tiles > 1) ? $clog2(num_tiles) : 1;
  endfunction

  function automatic logic [IO_CFG_MAX_TILES-1:0] io_cfg_one_hot(input logic [7:0] idx);
    logic [IO_CFG_MAX_TILES-1:0] vec;
    vec = '0;
    for (int i = 0; i < IO_CFG_MAX_TILES; i++) begin
      vec[i] = (idx == 8'(i));
    end
    return vec;
  endfunction

endpackage

// File: rtl/io_cfg_bit_counter.sv
// io_cfg_bit_counter
//   Position of the next configuration bit in the stream: address within
//   the tile (low digit) and tile index (high digit).
//   Ports:
//     prog_clk, prog_reset_n : clock, synchronous active-low reset
//     clear                  : restart at tile 0, address 0
//     incr                   : advance one bit (address wraps into tile)
//     addr_cnt, tile_cnt     : current address / tile
//     is_final               : current position is the last bit of the stream
module io_cfg_bit_counter
  import io_cfg_pkg::*;
#(
  parameter int NUM_TILES = IO_CFG_NUM_TILES,
  parameter int ADDR_W    = IO_CFG_ADDR_W,
  localparam int TILE_W   = io_cfg_tile_w(NUM_TILES)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              clear,
  input  logic              incr,
  output logic [ADDR_W-1:0] addr_cnt,
  output logic [TILE_W-1:0] tile_cnt,
  output logic              is_final
);

  // The tile count need not be a power of two, so the top tile is explicit.
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);

  logic addr_at_max;

  assign addr_at_max = (addr_cnt == '1);
  assign is_final    = addr_at_max && (tile_cnt == TILE_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      addr_cnt <= '0;
      tile_cnt <= '0;
    end else if (clear) begin
      addr_cnt <= '0;
      tile_cnt <= '0;
    end else if (incr) begin
      addr_cnt <= addr_cnt + ADDR_W'(1);
      if (addr_at_max) begin
        tile_cnt <= (tile_cnt == TILE_LAST) ? '0 : tile_cnt + TILE_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_cfg_frame_loader.sv
// io_cfg_frame_loader
//   Accepts a serial configuration bitstream over valid/ready and writes it
//   bit by bit into the I/O tiles of one grid side. Each bit is presented on
//   the shared address/data_in bus, then strobed into one tile with a single
//   cycle one-hot enable pulse framed by quiet cycles on either side.
//   Ports:
//     prog_clk, prog_reset_n     : clock, synchronous active-low reset
//     start                      : begin a load (ignored while busy)
//     bs_valid/bs_data/bs_last   : bitstream input, bs_last on the final bit
//     bs_ready                   : a bit is accepted this cycle
//     enable                     : one-hot per-tile write strobe
//     address, data_in           : shared configuration bus
//     busy, done, error          : load in progress / completed / aborted
module io_cfg_frame_loader
  import io_cfg_pkg::*;
#(
  parameter int NUM_TILES = IO_CFG_NUM_TILES,
  parameter int ADDR_W    = IO_CFG_ADDR_W,
  localparam int TILE_W   = io_cfg_tile_w(NUM_TILES)
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset_n,
  input  logic                 start,
  input  logic                 bs_valid,
  input  logic                 bs_data,
  input  logic                 bs_last,
  output logic                 bs_ready,
  output logic [NUM_TILES-1:0] enable,
  output logic [ADDR_W-1:0]    address,
  output logic                 data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  io_cfg_state_t        state;
  logic                 cnt_clear;
  logic                 cnt_incr;
  logic [ADDR_W-1:0]    addr_cnt;
  logic [TILE_W-1:0]    tile_cnt;
  logic                 is_final;
  logic [NUM_TILES-1:0] strobe_vec;
  logic                 can_start;

  io_cfg_bit_counter #(
    .NUM_TILES (NUM_TILES),
    .ADDR_W    (ADDR_W)
  ) u_bit_counter (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .clear        (cnt_clear),
    .incr         (cnt_incr),
    .addr_cnt     (addr_cnt),
    .tile_cnt     (tile_cnt),
    .is_final     (is_final)
  );

  assign strobe_vec = NUM_TILES'(io_cfg_one_hot(8'(tile_cnt)));
  assign can_start  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path can leave a value held and infer a latch.
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;
    if (start && can_start) cnt_clear = 1'b1;
    // Advance in HOLD: is_final is still judged on the bit just written.
    if (state == S_HOLD)    cnt_incr  = 1'b1;
  end

  // All outputs are registered, so the tile inputs only ever see clean edges.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state    <= S_IDLE;
      enable   <= '0;
      address  <= '0;
      data_in  <= 1'b0;
      bs_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_WAIT_BIT;
            bs_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        S_WAIT_BIT: begin
          // bs_ready is high throughout this state, so bs_valid is the handshake.
          if (bs_valid) begin
            data_in  <= bs_data;
            address  <= addr_cnt;
            bs_ready <= 1'b0;
            if (bs_last == is_final) begin
              state <= S_SETUP;
            end else begin
              // Stream length disagrees with the grid: abort without writing.
              state <= S_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          state  <= S_STROBE;
          enable <= strobe_vec;
        end
        S_STROBE: begin
          state  <= S_HOLD;
          enable <= '0;
        end
        S_HOLD: begin
          if (is_final) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= S_WAIT_BIT;
            bs_ready <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          enable   <= '0;
          bs_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_cfg_frame_loader.sv
// tb_io_cfg_frame_loader
//   Randomized bench for io_cfg_frame_loader. The driver pushes the expected
//   write for every accepted bit into a queue; an independent monitor pops an
//   entry whenever a strobe appears and checks tile, address, data and the
//   quiet cycles around the pulse.
module tb_io_cfg_frame_loader;

  localparam int NT    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int NBITS = NT * DEPTH;

  typedef struct {
    int tile;
    int addr;
    bit data;
  } wr_t;

  logic          prog_clk;
  logic          prog_reset_n;
  logic          start;
  logic          bs_valid;
  logic          bs_data;
  logic          bs_last;
  logic          bs_ready;
  logic [NT-1:0] enable;
  logic [AW-1:0] address;
  logic          data_in;
  logic          busy;
  logic          done;
  logic          error;

  int  n_vec;
  int  n_err;
  int  cyc;
  int  strobe_cnt;
  wr_t exp_q[$];

  io_cfg_frame_loader #(
    .NUM_TILES (NT),
    .ADDR_W    (AW)
  ) dut (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .start        (start),
    .bs_valid     (bs_valid),
    .bs_data      (bs_data),
    .bs_last      (bs_last),
    .bs_ready     (bs_ready),
    .enable       (enable),
    .address      (address),
    .data_in      (data_in),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [AW-1:0] prev_addr;
  logic          prev_data;
  bit            pend;
  logic [AW-1:0] pend_addr;
  logic          pend_data;

  always @(negedge prog_clk) begin
    wr_t e;
    if (pend) begin
      pend = 1'b0;
      // A reset right after the pulse legitimately clears the bus.
      if (prog_reset_n) begin
        check("strobe_width", 32'(enable), 32'd0);
        check("post_hold_addr", 32'(address), 32'(pend_addr));
        check("post_hold_data", 32'(data_in), 32'(pend_data));
      end
    end
    if (bs_ready) check("no_strobe_in_wait", 32'(enable), 32'd0);
    if (enable != '0) begin
      strobe_cnt++;
      check("pre_hold_addr", 32'(address), 32'(prev_addr));
      check("pre_hold_data", 32'(data_in), 32'(prev_data));
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(enable), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_enable", 32'(enable), 32'd1 << e.tile);
        check("strobe_addr", 32'(address), 32'(e.addr));
        check("strobe_data", 32'(data_in), 32'(e.data));
      end
      pend      = 1'b1;
      pend_addr = address;
      pend_data = data_in;
    end
    prev_addr = address;
    prev_data = data_in;
  end

  // ---------------- driver ----------------
  // Sends bits 0..n_bits-1; bs_last is raised on bit last_at (-1: never).
  // start is pulsed alongside bit start_at (-1: never).
  task automatic run_stream(input int n_bits, input int last_at, input int gap_pct,
                            input bit rand_data, input int start_at, input bit chk_spacing);
    int prev_hs;
    prev_hs = 0;
    for (int k = 0; k < n_bits; k++) begin
      bit d;
      bit hs;
      int tries;
      d     = rand_data ? ($urandom_range(1) == 1) : ((k % 3) == 0);
      hs    = 1'b0;
      tries = 0;
      while (!hs) begin
        @(negedge prog_clk);
        start    = (k == start_at) && (tries == 0);
        bs_valid = ($urandom_range(99) >= gap_pct);
        bs_data  = d;
        bs_last  = (k == last_at);
        hs       = bs_valid && bs_ready;
        tries++;
        if (hs) begin
          // Reference: bit k lives at tile k/DEPTH, address k%DEPTH, and is
          // written only if its last flag agrees with the stream length.
          if ((k == last_at) == (k == NBITS - 1))
            exp_q.push_back('{tile: k / DEPTH, addr: k % DEPTH, data: d});
          if (chk_spacing && k > 0) check("handshake_spacing", 32'(cyc - prev_hs), 32'd4);
          prev_hs = cyc;
        end else if (tries > 200) begin
          n_vec++;
          n_err++;
          $display("FAIL handshake_timeout: bit %0d not accepted within 200 cycles", k);
          #1;
          bs_valid = 1'b0;
          start    = 1'b0;
          return;
        end
        @(posedge prog_clk);
      end
    end
    #1;
    bs_valid = 1'b0;
    bs_last  = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_start();
    @(negedge prog_clk);
    start = 1'b1;
    @(posedge prog_clk);
    @(negedge prog_clk);
    start = 1'b0;
    check("start_ready", 32'(bs_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    check("start_error_clr", 32'(error), 32'd0);
  endtask

  // Called right after the final handshake edge: done rises three edges later.
  task automatic expect_done(input int strobes_before);
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk);
    check("done_not_early", 32'(done), 32'd0);
    check("busy_in_hold", 32'(busy), 32'd1);
    @(posedge prog_clk);
    @(negedge prog_clk);
    check("done", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_ready", 32'(bs_ready), 32'd0);
    check("done_error", 32'(error), 32'd0);
    check("strobe_count", 32'(strobe_cnt - strobes_before), 32'(NBITS));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_enable"}, 32'(enable), 32'd0);
    check({tag, "_address"}, 32'(address), 32'd0);
    check({tag, "_data_in"}, 32'(data_in), 32'd0);
    check({tag, "_bs_ready"}, 32'(bs_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int s0;
    n_vec = 0; n_err = 0; cyc = 0; strobe_cnt = 0;
    pend = 1'b0; prev_addr = '0; prev_data = 1'b0;
    pend_addr = '0; pend_data = 1'b0;
    bs_valid = 1'b0; bs_data = 1'b0; bs_last = 1'b0;
    // start held during reset: reset must win.
    prog_reset_n = 1'b0;
    start        = 1'b1;
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    check_reset_vals("reset");
    start        = 1'b0;
    prog_reset_n = 1'b1;
    @(negedge prog_clk);
    check("idle_no_ready", 32'(bs_ready), 32'd0);

    // 1) Full stream, valid held high, k%3==0 pattern, 4-cycle spacing.
    s0 = strobe_cnt;
    do_start();
    run_stream(NBITS, NBITS - 1, 0, 1'b0, -1, 1'b1);
    expect_done(s0);

    // 2) Same pattern with ~30% idle cycles on bs_valid.
    s0 = strobe_cnt;
    do_start();
    run_stream(NBITS, NBITS - 1, 30, 1'b0, -1, 1'b0);
    expect_done(s0);

    // 3) Early bs_last on bit 20: abort, nothing written for that bit.
    s0 = strobe_cnt;
    do_start();
    run_stream(21, 20, 20, 1'b1, -1, 1'b0);
    @(negedge prog_clk);
    check("early_last_error", 32'(error), 32'd1);
    check("early_last_busy", 32'(busy), 32'd0);
    check("early_last_done", 32'(done), 32'd0);
    repeat (6) @(negedge prog_clk);
    check("early_last_strobes", 32'(strobe_cnt - s0), 32'd20);
    check("early_last_ready", 32'(bs_ready), 32'd0);
    s0 = strobe_cnt;
    do_start();
    run_stream(NBITS, NBITS - 1, 30, 1'b1, -1, 1'b0);
    expect_done(s0);

    // 4) bs_last missing on bit 63: abort, only 63 strobes.
    s0 = strobe_cnt;
    do_start();
    run_stream(NBITS, -1, 25, 1'b1, -1, 1'b0);
    @(negedge prog_clk);
    check("missing_last_error", 32'(error), 32'd1);
    check("missing_last_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge prog_clk);
    check("missing_last_strobes", 32'(strobe_cnt - s0), 32'(NBITS - 1));
    check("missing_last_done", 32'(done), 32'd0);

    // 5) Reset during the strobe of bit 5, with start also asserted.
    do_start();
    run_stream(6, -1, 0, 1'b1, -1, 1'b0);
    @(posedge prog_clk);
    #2;
    check("strobe_before_reset", 32'(enable), 32'd1);
    prog_reset_n = 1'b0;
    start        = 1'b1;
    @(posedge prog_clk);
    @(negedge prog_clk);
    check_reset_vals("midreset");
    @(posedge prog_clk);
    @(negedge prog_clk);
    start        = 1'b0;
    prog_reset_n = 1'b1;
    check("midreset_queue", 32'(exp_q.size()), 32'd0);
    s0 = strobe_cnt;
    do_start();
    run_stream(NBITS, NBITS - 1, 20, 1'b1, -1, 1'b0);
    expect_done(s0);

    // 6) start pulsed while bit 10 is offered: must be ignored.
    s0 = strobe_cnt;
    do_start();
    run_stream(NBITS, NBITS - 1, 30, 1'b1, 10, 1'b0);
    expect_done(s0);

    // done is sticky until the next start.
    repeat (5) @(negedge prog_clk);
    check("done_sticky", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
